instr_encoder: RTL and testbench

- Encoder counterpart of the main control decoder: turns decoded instruction descriptors (op class plus fields) into 32-bit MIPS instruction words.
- Buffers encoded words in a FIFO and streams them out with sequential byte addresses through a valid/ready handshake.
- Used by testbench and boot loaders to fill instruction memory (R-type, lw, sw, beq, j, lui, ori).

---
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: descriptors in, 32-bit words out through a FIFO with sequential byte addresses.
// Optional INSTR_ENCODER_STATS_EN adds a saturating word_count output (emits since rst/flush).
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err
`ifdef INSTR_ENCODER_STATS_EN
    ,
    output logic [31:0] word_count
`endif
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [2:0]  OP_ILLEGAL = 3'd7;

    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    w = {6'b100011, rs, rt, imm};
            3'd2:    w = {6'b101011, rs, rt, imm};
            3'd3:    w = {6'b000100, rs, rt, imm};
            3'd4:    w = {6'b000010, target};
            3'd5:    w = {6'b001111, 5'b00000, rt, imm};
            3'd6:    w = {6'b001101, rs, rt, imm};
            default: w = 32'h0000_0000;
        endcase
        encode = w;
    endfunction

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          valid_q, err_q;
    logic [31:0]   word_q, addr_q;
    logic [31:0]   enc_word, head_d;
    logic          accept, illegal, push, pop, head_from_in;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = valid_q;
    assign out_word  = word_q;
    assign out_addr  = addr_q;
    assign err       = err_q;

    always_comb begin
        enc_word     = encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
        accept       = in_valid && in_ready && !flush;
        illegal      = accept && (in_op == OP_ILLEGAL);
        push         = accept && !illegal;
        pop          = valid_q && out_ready && !flush;
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // The incoming word becomes head when nothing else remains ahead of it.
        head_from_in = push && ((count_q == '0) || ((count_q == (AW+1)'(1)) && pop));
        head_d       = head_from_in ? enc_word : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            word_q   <= 32'h0000_0000;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= (count_d != '0);
            if (count_d != '0) begin
                word_q <= head_d;
            end
            if (pop) begin
                addr_q <= addr_q + 32'd4;
            end
            if (illegal) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENCODER_STATS_EN
    logic [31:0] word_count_q;

    assign word_count = word_count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            word_count_q <= 32'h0000_0000;
        end else if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
            word_count_q <= word_count_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (base 0 and a wrapping base) share stimulus and a queue model.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready0, out_valid0, err0, in_ready1, out_valid1, err1;
    logic [31:0] out_word0, out_addr0, out_word1, out_addr1;
`ifdef INSTR_ENCODER_STATS_EN
    logic [31:0] wc0, wc1;
`endif

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid0), .out_ready(out_ready), .out_word(out_word0),
        .out_addr(out_addr0), .err(err0)
`ifdef INSTR_ENCODER_STATS_EN
        , .word_count(wc0)
`endif
    );

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid1), .out_ready(out_ready), .out_word(out_word1),
        .out_addr(out_addr1), .err(err1)
`ifdef INSTR_ENCODER_STATS_EN
        , .word_count(wc1)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the opcode table and field bit positions.
    function automatic logic [31:0] model_word(input logic [2:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] tgt);
        logic [5:0]  opc_tab [7];
        logic [31:0] opc;
        opc_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h0F, 6'h0D};
        opc = 32'(opc_tab[op]) * 32'h0400_0000;
        if (op == 3'd0)
            return 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(rd) * 32'h800
                 + 32'(sh) * 32'h40 + 32'(fn);
        if (op == 3'd4)
            return opc + 32'(tgt);
        if (op == 3'd5)
            return opc + 32'(rt) * 32'h1_0000 + 32'(imm);
        return opc + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(imm);
    endfunction

    logic [31:0] mq [$];
    logic [31:0] m_emits;
    logic        m_err;
    logic [31:0] m_wc;

    initial begin
        m_emits = 0; m_err = 0; m_wc = 0;
        forever begin
            @(posedge clk);
            if (rst || flush) begin
                mq.delete();
                m_emits = 0; m_err = 0; m_wc = 0;
            end else begin
                logic acc, emit;
                acc  = in_valid && (mq.size() < DEPTH);
                emit = (mq.size() != 0) && out_ready;
                if (emit) begin
                    void'(mq.pop_front());
                    m_emits = m_emits + 1;
                    if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
                end
                if (acc) begin
                    if (in_op == 3'd7) m_err = 1'b1;
                    else mq.push_back(model_word(in_op, in_rs, in_rt, in_rd, in_shamt,
                                                 in_funct, in_imm, in_target));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("out_valid0", out_valid0, mq.size() != 0);
                chk("out_valid1", out_valid1, mq.size() != 0);
                chk("in_ready0", in_ready0, mq.size() < DEPTH);
                chk("in_ready1", in_ready1, mq.size() < DEPTH);
                chk("err0", err0, m_err);
                chk("err1", err1, m_err);
                if (mq.size() != 0) begin
                    chk("out_word0", out_word0, mq[0]);
                    chk("out_word1", out_word1, mq[0]);
                    chk("out_addr0", out_addr0, BASE0 + m_emits * 4);
                    chk("out_addr1", out_addr1, BASE1 + m_emits * 4);
                end
`ifdef INSTR_ENCODER_STATS_EN
                chk("word_count0", wc0, m_wc);
                chk("word_count1", wc1, m_wc);
`endif
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] tgt);
        logic ok;
        ok = 1'b0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ok = in_ready0;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        chk("push_accept", ok, 1'b1);
    endtask

    task automatic single(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] tgt,
        input logic [31:0] exp_word, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
        out_ready = 1'b0;
        push(op, rs, rt, rd, sh, fn, imm, tgt);
        chk("lit_valid", out_valid0, 1'b1);
        chk("lit_word0", out_word0, exp_word);
        chk("lit_word1", out_word1, exp_word);
        chk("lit_addr0", out_addr0, exp_a0);
        chk("lit_addr1", out_addr1, exp_a1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("lit_emptied", out_valid0, 1'b0);
    endtask

    task automatic do_flush();
        in_op = 3'd1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (!out_valid0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_done", out_valid0, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_shamt = 0;
        in_funct = 0; in_imm = 0; in_target = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        chk("rst_valid", out_valid0, 1'b0);
        chk("rst_word", out_word0, 32'h0);
        chk("rst_addr0", out_addr0, 32'h0);
        chk("rst_addr1", out_addr1, 32'hFFFF_FFF8);
        chk("rst_err", err0, 1'b0);
        chk("rst_in_ready", in_ready0, 1'b1);

        single(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0,
               32'h8FA8_0004, 32'h0, 32'hFFFF_FFF8);

        // Back-to-back streaming with the consumer always ready.
        do_flush();
        out_ready = 1'b1;
        push(3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'd0);
        push(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010);
        drain();

        do_flush();
        single(3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'd0, 32'h012A_4020, 32'h0, 32'hFFFF_FFF8);
        single(3'd4, 5'd3, 5'd3, 5'd3, 5'd3, 6'd3, 16'h3, 26'h0000010, 32'h0800_0010, 32'h4, 32'hFFFF_FFFC);
        single(3'd5, 5'd31, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 32'h3C01_1234, 32'h8, 32'h0);
        single(3'd6, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h5678, 26'd0, 32'h3421_5678, 32'hC, 32'h4);

        // Fill to DEPTH with the consumer stalled, then hold a fifth descriptor.
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push(3'd1, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i * 4), 26'd0);
        chk("full_in_ready", in_ready0, 1'b0);
        in_op = 3'd2; in_rs = 5'd7; in_rt = 5'd9; in_imm = 16'h00AA; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("held_in_ready", in_ready0, 1'b0);
        chk("held_word", out_word0, 32'h8C01_0000);
        chk("held_addr", out_addr0, 32'h0);
        out_ready = 1'b1;
        push(3'd2, 5'd7, 5'd9, 5'd0, 5'd0, 6'd0, 16'h00AA, 26'd0);
        drain();
        chk("five_emits_addr", out_addr0, 32'd20);

        // Illegal op followed by beq, then flush.
        do_flush();
        out_ready = 1'b0;
        push(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'd1);
        chk("illegal_err", err0, 1'b1);
        chk("illegal_nopush", out_valid0, 1'b0);
        push(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        chk("beq_word", out_word0, 32'h1022_FFFF);
        chk("beq_addr", out_addr0, 32'h0);
        drain();
        chk("err_sticky", err0, 1'b1);
        do_flush();
        chk("flush_err", err0, 1'b0);
        chk("flush_valid", out_valid0, 1'b0);
        chk("flush_addr0", out_addr0, 32'h0);
        chk("flush_addr1", out_addr1, 32'hFFFF_FFF8);
        chk("flush_in_ready", in_ready0, 1'b1);

        // Mixed traffic with a periodic consumer stall.
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 3) != 0;
            push((i == 13) ? 3'd7 : 3'(i % 7), 5'(i), 5'(i * 3), 5'(31 - i), 5'(i * 7),
                 6'(i * 5), 16'(i * 16'h1357), 26'(i * 26'h12345));
        end
        drain();

        // Reset wins over flush and handshakes.
        out_ready = 1'b0;
        push(3'd6, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0F0F, 26'd0);
        push(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_op = 3'd7; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("rst2_valid", out_valid0, 1'b0);
        chk("rst2_err", err0, 1'b0);
        chk("rst2_word", out_word0, 32'h0);
        chk("rst2_addr1", out_addr1, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
